// File: rtl/seqdet_run_ctrl.sv
// seqdet_run_ctrl
// Run controller for the sequence-detector datapath: latches an 8-bit pattern
// and replays it MSB-first on dout for a programmable number of frames, one
// bit per divider tick. The detector is cleared before each run, and the
// controller counts its hits.
// Optional build macro SEQCTRL_FIRST_HIT_EN adds the first_hit/first_hit_vld
// outputs, which report the run-relative tick of the first counted hit.
module seqdet_run_ctrl #(
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 8,
    parameter int FLUSH_TICKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] indata,
    input  logic [3:0]       rounds,
    input  logic             z_in,
    output logic             dout,
    output logic             det_rst,
    output logic             busy,
    output logic             done,
    output logic [2:0]       bit_idx,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [2:0]       state
`ifdef SEQCTRL_FIRST_HIT_EN
    ,
    output logic [CNT_W-1:0] first_hit,
    output logic             first_hit_vld
`endif
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [3:0]       r_rounds;
    logic [3:0]       r_frame_cnt;
    logic [7:0]       r_flush_cnt;
    logic             r_dout;
    logic [2:0]       r_bit_idx;
    logic [CNT_W-1:0] r_hit_cnt;

    logic w_run_tick;
    logic w_hit;

    // Ticks only count while the stream (data or flush) is being driven.
    assign w_run_tick = tick && ((r_state == ST_SHIFT) || (r_state == ST_FLUSH));
    assign w_hit      = w_run_tick && z_in;

    // Main run sequencer: start/abort handling, serial shifting, flush and hit counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_rounds    <= '0;
            r_frame_cnt <= '0;
            r_flush_cnt <= '0;
            r_dout      <= 1'b0;
            r_bit_idx   <= '0;
            r_hit_cnt   <= '0;
        end else if (abort && (r_state != ST_IDLE)) begin
            // Abort wins over start and over a coincident hit; hit_cnt is held.
            r_state <= ST_IDLE;
            r_dout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start && !abort) begin
                        r_shreg     <= indata;
                        r_rounds    <= (rounds == 4'd0) ? 4'd1 : rounds;
                        r_hit_cnt   <= '0;
                        r_frame_cnt <= '0;
                        r_flush_cnt <= '0;
                        r_bit_idx   <= '0;
                        r_dout      <= 1'b0;
                        r_state     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (tick) begin
                        r_dout  <= r_shreg[WIDTH-1];
                        r_shreg <= {r_shreg[WIDTH-2:0], r_shreg[WIDTH-1]};
                        if (r_bit_idx == 3'(WIDTH - 1)) begin
                            r_bit_idx   <= '0;
                            r_frame_cnt <= r_frame_cnt + 4'd1;
                            if (r_frame_cnt == (r_rounds - 4'd1)) begin
                                r_flush_cnt <= '0;
                                r_state     <= ST_FLUSH;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (tick) begin
                        r_dout <= 1'b0;
                        if (r_flush_cnt == 8'(FLUSH_TICKS - 1)) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_flush_cnt <= r_flush_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_dout  <= 1'b0;
                end
            endcase

            if (w_hit && !(&r_hit_cnt)) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
        end
    end

`ifdef SEQCTRL_FIRST_HIT_EN
    logic [CNT_W-1:0] r_tick_num;
    logic [CNT_W-1:0] r_first_hit;
    logic             r_first_hit_vld;

    // Tracks the run-relative tick number and captures it at the first counted hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_num      <= '0;
            r_first_hit     <= '0;
            r_first_hit_vld <= 1'b0;
        end else if (abort && (r_state != ST_IDLE)) begin
            r_tick_num      <= '0;
            r_first_hit     <= '0;
            r_first_hit_vld <= 1'b0;
        end else if (((r_state == ST_IDLE) || (r_state == ST_DONE)) && start && !abort) begin
            r_tick_num      <= '0;
            r_first_hit     <= '0;
            r_first_hit_vld <= 1'b0;
        end else if (w_run_tick) begin
            r_tick_num <= r_tick_num + 1'b1;
            if (z_in && !r_first_hit_vld) begin
                r_first_hit     <= r_tick_num;
                r_first_hit_vld <= 1'b1;
            end
        end
    end

    assign first_hit     = r_first_hit;
    assign first_hit_vld = r_first_hit_vld;
`endif

    assign dout    = r_dout;
    assign det_rst = (r_state == ST_CLEAR);
    assign busy    = (r_state == ST_CLEAR) || (r_state == ST_SHIFT) || (r_state == ST_FLUSH);
    assign done    = (r_state == ST_DONE);
    assign bit_idx = r_bit_idx;
    assign hit_cnt = r_hit_cnt;
    assign state   = r_state;

endmodule

// File: tb/tb_seqdet_run_ctrl.sv
// Testbench for seqdet_run_ctrl: randomized tick spacing, z_in and mid-run
// start/indata noise, checked against a stream-level reference model.
// Two instances share all inputs: default CNT_W=8 and CNT_W=2 (saturation).
module tb_seqdet_run_ctrl;

    localparam int FLUSH = 2;

    logic       clk = 1'b0;
    logic       rst, tick, start, abort, z_in;
    logic [7:0] indata;
    logic [3:0] rounds;

    logic       dout, det_rst, busy, done;
    logic [2:0] bit_idx, state;
    logic [7:0] hit_cnt;

    logic       dout2, det_rst2, busy2, done2;
    logic [2:0] bit_idx2, state2;
    logic [1:0] hit_cnt2;

`ifdef SEQCTRL_FIRST_HIT_EN
    logic [7:0] first_hit;
    logic       first_hit_vld;
    logic [1:0] first_hit2;
    logic       first_hit_vld2;
`endif

    int checks   = 0;
    int failures = 0;

    seqdet_run_ctrl #(.WIDTH(8), .CNT_W(8), .FLUSH_TICKS(FLUSH)) u_dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .abort(abort),
        .indata(indata), .rounds(rounds), .z_in(z_in),
        .dout(dout), .det_rst(det_rst), .busy(busy), .done(done),
        .bit_idx(bit_idx), .hit_cnt(hit_cnt), .state(state)
`ifdef SEQCTRL_FIRST_HIT_EN
        , .first_hit(first_hit), .first_hit_vld(first_hit_vld)
`endif
    );

    seqdet_run_ctrl #(.WIDTH(8), .CNT_W(2), .FLUSH_TICKS(FLUSH)) u_dut_sat (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .abort(abort),
        .indata(indata), .rounds(rounds), .z_in(z_in),
        .dout(dout2), .det_rst(det_rst2), .busy(busy2), .done(done2),
        .bit_idx(bit_idx2), .hit_cnt(hit_cnt2), .state(state2)
`ifdef SEQCTRL_FIRST_HIT_EN
        , .first_hit(first_hit2), .first_hit_vld(first_hit_vld2)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One run: zmode 0=never,1=always,2=random,3=ticks 5/13/21,4=tick 3 only.
    task automatic do_run(input logic [7:0] pat, input logic [3:0] rnds,
                          input int zmode, input int abort_after);
        int r, n, hits, fh, gap, sat2;
        logic zb;
        logic [7:0] pat_v;
        pat_v = pat;
        r     = (rnds == 4'd0) ? 1 : int'(rnds);
        n     = r * 8 + FLUSH;
        hits  = 0;
        fh    = -1;

        indata = pat; rounds = rnds; start = 1'b1; z_in = 1'b0; tick = 1'b0; abort = 1'b0;
        step();
        chk("clr_state",   32'(state), 1);
        chk("clr_det_rst", 32'(det_rst), 1);
        chk("clr_busy",    32'(busy), 1);
        chk("clr_done",    32'(done), 0);
        chk("clr_dout",    32'(dout), 0);
        chk("clr_hit",     32'(hit_cnt), 0);
        chk("clr_hit2",    32'(hit_cnt2), 0);

        // tick and z_in during CLEAR must be ignored
        start = 1'b0; tick = 1'($urandom_range(0, 1)); z_in = 1'b1;
        step();
        tick = 1'b0; z_in = 1'b0;
        chk("sh0_state",   32'(state), 2);
        chk("sh0_det_rst", 32'(det_rst), 0);
        chk("sh0_dout",    32'(dout), 0);
        chk("sh0_bit_idx", 32'(bit_idx), 0);
        chk("sh0_hit",     32'(hit_cnt), 0);

        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                z_in   = 1'($urandom_range(0, 1));
                start  = 1'($urandom_range(0, 1));
                indata = 8'($urandom);
                rounds = 4'($urandom);
                step();
            end
            start = 1'b0;
            case (zmode)
                0: zb = 1'b0;
                1: zb = 1'b1;
                2: zb = 1'($urandom_range(0, 1));
                3: zb = (k == 5) || (k == 13) || (k == 21);
                default: zb = (k == 3);
            endcase
            tick = 1'b1; z_in = zb;
            step();
            tick = 1'b0; z_in = 1'b0;
            if (zb) begin
                hits++;
                if (fh < 0) fh = k;
            end
            sat2 = (hits > 3) ? 3 : hits;

            chk("dout", 32'(dout), (k < r * 8) ? 32'(pat_v[7 - (k % 8)]) : 0);
            chk("state", 32'(state), (k < r * 8 - 1) ? 2 : ((k < n - 1) ? 3 : 4));
            chk("bit_idx", 32'(bit_idx), (k < r * 8) ? 32'((k + 1) % 8) : 0);
            chk("hit_cnt", 32'(hit_cnt), 32'(hits));
            chk("hit_cnt_sat", 32'(hit_cnt2), 32'(sat2));
            chk("busy", 32'(busy), (k < n - 1) ? 1 : 0);
            chk("done", 32'(done), (k < n - 1) ? 0 : 1);
`ifdef SEQCTRL_FIRST_HIT_EN
            chk("fh_vld", 32'(first_hit_vld), (fh >= 0) ? 1 : 0);
            chk("fh", 32'(first_hit), (fh >= 0) ? 32'(fh % 256) : 0);
            chk("fh_sat", 32'(first_hit2), (fh >= 0) ? 32'(fh % 4) : 0);
`endif
            if (k == abort_after) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                chk("ab_state",   32'(state), 0);
                chk("ab_dout",    32'(dout), 0);
                chk("ab_busy",    32'(busy), 0);
                chk("ab_done",    32'(done), 0);
                chk("ab_det_rst", 32'(det_rst), 0);
                chk("ab_hit",     32'(hit_cnt), 32'(hits));
`ifdef SEQCTRL_FIRST_HIT_EN
                chk("ab_fh_vld",  32'(first_hit_vld), 0);
                chk("ab_fh",      32'(first_hit), 0);
`endif
                return;
            end
        end

        // DONE holds with ticks and z_in still arriving
        tick = 1'b1; z_in = 1'b1;
        step(); step();
        tick = 1'b0; z_in = 1'b0;
        chk("dn_state", 32'(state), 4);
        chk("dn_done",  32'(done), 1);
        chk("dn_busy",  32'(busy), 0);
        chk("dn_dout",  32'(dout), 0);
        chk("dn_hit",   32'(hit_cnt), 32'(hits));
        chk("dn_hit2",  32'(hit_cnt2), 32'((hits > 3) ? 3 : hits));
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; abort = 1'b0; z_in = 1'b1;
        indata = 8'hB4; rounds = 4'd1; tick = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick = (c % 4 == 0);
            step();
        end
        chk("rst_state",   32'(state), 0);
        chk("rst_dout",    32'(dout), 0);
        chk("rst_det_rst", 32'(det_rst), 0);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_done",    32'(done), 0);
        chk("rst_bit_idx", 32'(bit_idx), 0);
        chk("rst_hit",     32'(hit_cnt), 0);
        rst = 1'b0; start = 1'b0; z_in = 1'b0; tick = 1'b0;
        step();
        chk("idle_state", 32'(state), 0);

        do_run(8'hB4, 4'd1, 0, -1);
        do_run(8'hB4, 4'd3, 3, -1);
        do_run(8'hFF, 4'd0, 2, -1);

        // abort together with start from DONE: abort wins, returns to IDLE
        abort = 1'b1; start = 1'b1;
        step();
        chk("as_state", 32'(state), 0);
        chk("as_done",  32'(done), 0);
        chk("as_busy",  32'(busy), 0);
        step();
        chk("as_idle_hold", 32'(state), 0);
        abort = 1'b0; start = 1'b0;

        do_run(8'hB4, 4'd2, 4, 10);
        step();
        chk("post_abort_idle", 32'(state), 0);

        do_run(8'h5A, 4'd1, 1, -1);

        for (int i = 0; i < 6; i++) begin
            do_run(8'($urandom), 4'($urandom_range(0, 3)), 2, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
